// File: rtl/spi_sram_pkg.sv
// Shared constants and state encoding for the SPI SRAM responder.
// Opcodes, address-mode encodings and the controller state enum.
package spi_sram_pkg;

    localparam logic [7:0] OP_WRMR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDMR  = 8'h05;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [7:0] MODE_RST  = 8'h40;

    localparam int PAGE_BYTES = 32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        MODE_RD,
        MODE_WR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_sram_responder_if.sv
// SPI pin bundle between an initiator (master) and the responder (slave).
interface spi_sram_responder_if;

    logic sclk;
    logic ce;
    logic si;
    logic so;
    logic so_oe;

    modport master (
        output sclk,
        output ce,
        output si,
        input  so,
        input  so_oe
    );

    modport slave (
        input  sclk,
        input  ce,
        input  si,
        output so,
        output so_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one async input plus one-clk rise/fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_lvl  = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 SRAM responder with inline byte array, oversampled on clk.
// Define SPI_SRAM_MODE_REG_EN to add the RDMR/WRMR mode register.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_sram_responder_if.slave  spi,
    output logic                 busy,
    output logic                 cmd_err
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [AW-1:0] PMASK = AW'(PAGE_BYTES - 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ce_lvl, w_ce_rise, w_ce_fall;
    logic w_si, w_si_rise, w_si_fall;
    logic w_unused;

    spi_sync_edge u_sync_sclk (
        .clk(clk), .reset(reset), .i_d(spi.sclk),
        .o_lvl(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge u_sync_ce (
        .clk(clk), .reset(reset), .i_d(spi.ce),
        .o_lvl(w_ce_lvl), .o_rise(w_ce_rise), .o_fall(w_ce_fall)
    );

    spi_sync_edge u_sync_si (
        .clk(clk), .reset(reset), .i_d(spi.si),
        .o_lvl(w_si), .o_rise(w_si_rise), .o_fall(w_si_fall)
    );

    assign w_unused = ^{w_sclk_lvl, w_ce_lvl, w_si_rise, w_si_fall};

    state_t          r_state;
    state_t          w_next;
    logic [4:0]      r_cnt;
    logic [7:0]      r_sh_in;
    logic [7:0]      r_sh_out;
    logic            r_so;
    logic            r_oe;
    logic            r_ld;
    logic            r_is_rd;
    logic            r_cmd_err;
    logic [AW-1:0]   r_ptr;
    logic [7:0]      r_mem [MEM_BYTES];

    logic [7:0]      w_byte;
    logic            w_last;
    logic            w_byte_done;
    logic            w_op_mem;
    logic            w_op_rdmr;
    logic            w_op_wrmr;
    logic            w_shift_rd;
    logic            w_we;
    logic            w_err;
    logic            w_ld;
    logic            w_adv;
    logic            w_mode_we;
    logic [7:0]      w_mode_byte;
    logic [1:0]      w_mode_sel;
    logic [AW-1:0]   w_ptr_inc;
    logic [AW-1:0]   w_ptr_nxt;

    assign w_byte      = {r_sh_in[6:0], w_si};
    assign w_last      = (r_cnt == ((r_state == ADDR) ? 5'd23 : 5'd7));
    assign w_byte_done = w_sclk_rise & w_last;

`ifdef SPI_SRAM_MODE_REG_EN
    logic [7:0] r_mode;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode <= MODE_RST;
        end else if (w_mode_we) begin
            r_mode <= w_byte;
        end
    end

    assign w_mode_byte = r_mode;
    assign w_op_rdmr   = (w_byte == OP_RDMR);
    assign w_op_wrmr   = (w_byte == OP_WRMR);
`else
    assign w_mode_byte = MODE_RST;
    assign w_op_rdmr   = 1'b0;
    assign w_op_wrmr   = 1'b0;
`endif

    assign w_mode_sel = w_mode_byte[7:6];
    assign w_op_mem   = (w_byte == OP_READ) || (w_byte == OP_WRITE);

    always_comb begin
        w_ptr_inc = r_ptr + AW'(1);
        w_ptr_nxt = w_ptr_inc;
        unique case (w_mode_sel)
            MODE_BYTE: w_ptr_nxt = r_ptr;
            MODE_PAGE: w_ptr_nxt = (r_ptr & ~PMASK) | (w_ptr_inc & PMASK);
            default:   w_ptr_nxt = w_ptr_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_ce_rise) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (w_ce_fall) w_next = CMD;
                CMD: begin
                    if (w_byte_done) begin
                        unique case (1'b1)
                            w_op_mem:  w_next = ADDR;
                            w_op_rdmr: w_next = MODE_RD;
                            w_op_wrmr: w_next = MODE_WR;
                            default:   w_next = IGNORE;
                        endcase
                    end
                end
                ADDR: if (w_byte_done) w_next = r_is_rd ? RD_DATA : WR_DATA;
                MODE_WR: if (w_byte_done) w_next = IGNORE;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_shift_rd = (r_state == RD_DATA) || (r_state == MODE_RD);
        w_we       = reset && (r_state == WR_DATA) && w_byte_done;
        w_adv      = w_byte_done
                   && ((r_state == RD_DATA) || (r_state == WR_DATA));
        w_err      = !w_ce_rise && (r_state == CMD) && w_byte_done
                   && !w_op_mem && !w_op_rdmr && !w_op_wrmr;
        w_mode_we  = !w_ce_rise && (r_state == MODE_WR) && w_byte_done;
        w_ld       = !w_ce_rise && w_byte_done
                   && (((r_state == ADDR) && r_is_rd)
                    || ((r_state == CMD) && w_op_rdmr)
                    || w_shift_rd);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_sh_in   <= '0;
            r_sh_out  <= '0;
            r_so      <= 1'b0;
            r_oe      <= 1'b0;
            r_ld      <= 1'b0;
            r_is_rd   <= 1'b0;
            r_cmd_err <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_cmd_err <= w_err;
            if (w_ce_rise || (r_state == IDLE)) begin
                r_cnt <= '0;
                r_so  <= 1'b0;
                r_oe  <= 1'b0;
                r_ld  <= 1'b0;
            end else begin
                r_ld <= w_ld;
                if (w_sclk_rise) begin
                    r_sh_in <= w_byte;
                    r_cnt   <= w_last ? 5'd0 : r_cnt + 5'd1;
                end
                if ((r_state == CMD) && w_byte_done) begin
                    r_is_rd <= (w_byte == OP_READ);
                end
                // address bits beyond the array width fall off the top
                if ((r_state == ADDR) && w_sclk_rise) begin
                    r_ptr <= {r_ptr[AW-2:0], w_si};
                end else if (w_adv) begin
                    r_ptr <= w_ptr_nxt;
                end
                if (r_ld) begin
                    r_sh_out <= (r_state == MODE_RD) ? w_mode_byte
                                                     : r_mem[r_ptr];
                end else if (w_shift_rd && w_sclk_fall) begin
                    r_so     <= r_sh_out[7];
                    r_sh_out <= {r_sh_out[6:0], 1'b0};
                    r_oe     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    assign spi.so    = r_so & r_oe;
    assign spi.so_oe = r_oe;
    assign busy      = (r_state != IDLE);
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI mode-0 initiator model,
// hand-computed expected bytes, one check task for all comparisons.
module tb_spi_sram_responder;

    localparam int MEM_BYTES = 4096;
    localparam int HALF      = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic       cmd_err;
    logic [7:0] junk;
    logic [31:0] q;

    int n_vec    = 0;
    int n_err    = 0;
    int n_pulse  = 0;
    int n_oe     = 0;
    int n_so_bad = 0;
    int p0;
    int o0;

    spi_sram_responder_if bus ();

    spi_sram_responder #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk     (clk),
        .reset   (reset),
        .spi     (bus),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err) n_pulse++;
        if (bus.so_oe) n_oe++;
        if (bus.so && !bus.so_oe) n_so_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            bus.si = tx[i];
            #HALF;
            rx[i] = bus.so;
            bus.sclk = 1'b1;
            #HALF;
            bus.sclk = 1'b0;
        end
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n);
        for (int i = 0; i < n; i++) begin
            bus.si = tx[7-i];
            #HALF;
            bus.sclk = 1'b1;
            #HALF;
            bus.sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        bus.ce = 1'b0;
        #HALF;
    endtask

    task automatic cs_hi();
        #HALF;
        bus.ce = 1'b1;
        #(4*HALF);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] d;
        xfer(op, d);
        xfer(a[23:16], d);
        xfer(a[15:8], d);
        xfer(a[7:0], d);
    endtask

    task automatic mem_write(input logic [23:0] a, input logic [31:0] data,
                             input int n);
        logic [7:0] d;
        cs_lo();
        hdr(8'h02, a);
        for (int k = n - 1; k >= 0; k--) xfer(data[8*k +: 8], d);
        cs_hi();
    endtask

    task automatic mem_read(input logic [23:0] a, input int n,
                            output logic [31:0] r);
        logic [7:0] d;
        r = '0;
        cs_lo();
        hdr(8'h03, a);
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, d);
            r = {r[23:0], d};
        end
        cs_hi();
    endtask

    task automatic op_only(input logic [7:0] op, input logic [7:0] b0,
                           input logic [7:0] b1, output logic [7:0] r);
        logic [7:0] d;
        cs_lo();
        xfer(op, d);
        xfer(b0, r);
        xfer(b1, d);
        cs_hi();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sclk = 1'b0;
        bus.ce   = 1'b1;
        bus.si   = 1'b0;
        reset    = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_so_oe", 32'(bus.so_oe), 32'd0);
        check("rst_so", 32'(bus.so), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        mem_write(24'h000010, 32'hDEADBEEF, 4);
        mem_read(24'h000010, 4, q);
        check("rd10_b0", 32'(q[31:24]), 32'hDE);
        check("rd10_b1", 32'(q[23:16]), 32'hAD);
        check("rd10_b2", 32'(q[15:8]), 32'hBE);
        check("rd10_b3", 32'(q[7:0]), 32'hEF);

        cs_lo();
        check("busy_in_xfer", 32'(busy), 32'd1);
        cs_hi();
        check("busy_after", 32'(busy), 32'd0);

        mem_write(24'(MEM_BYTES - 1), 32'h00001122, 2);
        mem_read(24'h000000, 1, q);
        check("seq_wrap_0", q, 32'h22);
        mem_read(24'h001FFF, 1, q);
        check("addr_hi_ignored", q, 32'h11);

        p0 = n_pulse;
        o0 = n_oe;
        op_only(8'h9F, 8'hFF, 8'hFF, junk);
        check("bad_op_pulse", 32'(n_pulse - p0), 32'd1);
        check("bad_op_oe", 32'(n_oe - o0), 32'd0);
        mem_read(24'h000010, 1, q);
        check("bad_op_mem", q, 32'hDE);

        mem_write(24'h000020, 32'h00000055, 1);
        cs_lo();
        hdr(8'h02, 24'h000020);
        xfer_bits(8'hA5, 5);
        cs_hi();
        mem_read(24'h000020, 1, q);
        check("partial_byte", q, 32'h55);

`ifdef SPI_SRAM_MODE_REG_EN
        op_only(8'h01, 8'h80, 8'h00, junk);
        mem_write(24'h00003F, 32'h00AABBCC, 3);
        mem_read(24'h00003F, 3, q);
        check("page_3f", 32'(q[23:16]), 32'hAA);
        check("page_20", 32'(q[15:8]), 32'hBB);
        check("page_21", 32'(q[7:0]), 32'hCC);
        mem_read(24'h000020, 1, q);
        check("page_20_rd", q, 32'hBB);
        op_only(8'h05, 8'h00, 8'h00, junk);
        check("rdmr_80", 32'(junk), 32'h80);
`else
        p0 = n_pulse;
        o0 = n_oe;
        op_only(8'h05, 8'h00, 8'h00, junk);
        op_only(8'h01, 8'h80, 8'h00, junk);
        check("mr_ops_err", 32'(n_pulse - p0), 32'd2);
        check("mr_ops_oe", 32'(n_oe - o0), 32'd0);
`endif

        cs_lo();
        hdr(8'h03, 24'h000010);
        xfer(8'h00, junk);
        check("rst_rd_b0", 32'(junk), 32'hDE);
        xfer_bits(8'h00, 3);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_oe", 32'(bus.so_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        o0 = n_oe;
        xfer_bits(8'h00, 5);
        xfer(8'h00, junk);
        cs_hi();
        check("post_rst_oe", 32'(n_oe - o0), 32'd0);
        mem_read(24'h000010, 4, q);
        check("post_rst_mem", q, 32'hDEADBEEF);
`ifdef SPI_SRAM_MODE_REG_EN
        op_only(8'h05, 8'h00, 8'h00, junk);
        check("post_rst_mode", 32'(junk), 32'h40);
`else
        mem_read(24'(MEM_BYTES - 1), 2, q);
        check("post_rst_seq", q, 32'h1122);
`endif

        check("so_without_oe", 32'(n_so_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_sram_responder.md
SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning internal byte-array size (power of two, 32..65536).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port sclk  input  1  SPI clock from initiator (mode 0), asynchronous to clk.
REQ-005 SHALL have port ce  input  1  SPI chip enable, active low, asynchronous.
REQ-006 SHALL have port si  input  1  serial data from initiator.
REQ-007 SHALL have port so  output  1  serial data to initiator.
REQ-008 SHALL have port so_oe  output  1  so drive enable; high only while shifting read/mode data.
REQ-009 SHALL have port busy  output  1  high while synchronized ce is low.
REQ-010 SHALL have port cmd_err  output  1  one-clk pulse on unknown opcode.

Function
REQ-011 SHALL pass sclk, ce, si through 2-flop synchronizers and derive one-clk rise/fall pulses of sclk and ce; supported sclk frequency is at most clk/4.
REQ-012 SHALL sample si on each synchronized sclk rise, MSB first; SHALL update so on each synchronized sclk fall.
REQ-013 SHALL use states IDLE, CMD, ADDR, RD_DATA, WR_DATA, MODE_RD, MODE_WR, IGNORE.
REQ-014 IDLE -> CMD on ce fall; any state -> IDLE on ce rise, discarding partial bytes and clearing so_oe.
REQ-015 CMD: after 8 bits, opcode 0x03 (READ) or 0x02 (WRITE) -> ADDR; 0x05 -> MODE_RD; 0x01 -> MODE_WR; any other opcode -> IGNORE with cmd_err pulsed once.
REQ-016 ADDR SHALL collect 24 address bits; pointer = addr mod MEM_BYTES (upper bits ignored); -> RD_DATA or WR_DATA after bit 24.
REQ-017 RD_DATA: byte at pointer SHALL be loaded into the shift register within 2 clk of the 24th address rise, so first data bit appears on so at the following sclk fall; next byte prefetched on the 8th rise of each byte.
REQ-018 WR_DATA: each complete 8-bit byte SHALL be written to pointer on its 8th rise, then pointer advances.
REQ-019 Pointer advance SHALL follow the mode: sequential wraps at MEM_BYTES-1 -> 0; page wraps within its 32-byte page; byte mode keeps pointer fixed.
REQ-020 IGNORE SHALL keep so_oe low and discard all bits until ce rise.
REQ-021 so SHALL be 0 whenever so_oe is 0.

Reset
REQ-022 On reset low: state IDLE, so=0, so_oe=0, busy=0, cmd_err=0, mode register=0x40 (sequential), synchronizers cleared.
REQ-023 Memory array contents SHALL NOT be reset.
REQ-024 Reset asserted mid-transaction SHALL abort it; no further writes until the next ce fall after reset release.

Configuration
REQ-025 Macro SPI_SRAM_MODE_REG_EN: defined -> MODE_RD shifts out mode register, MODE_WR loads it from the first byte; bits[7:6] 00=byte, 10=page, 01=sequential, 11=sequential.
REQ-026 Without SPI_SRAM_MODE_REG_EN: opcodes 0x01/0x05 are unknown (cmd_err, IGNORE), mode fixed sequential, no mode register flops.

Structure
REQ-027 Package spi_sram_pkg SHALL hold opcode constants, mode encodings, and the state enum.
REQ-028 Sub-module spi_sync_edge SHALL implement one synchronizer plus rise/fall detect, instantiated per input.
REQ-029 Memory array SHALL be inline, one write port and one read port.

Verification
REQ-030 WRITE 0x02, addr 0x000010, bytes DE AD BE EF, then READ 0x03 at 0x000010 for 4 bytes -> so returns DE AD BE EF.
REQ-031 Sequential WRITE at MEM_BYTES-1 of 0x11 0x22 -> READ at 0 returns 0x22.
REQ-032 Opcode 0x9F then 16 clocks -> cmd_err single pulse, so_oe stays 0, memory unchanged.
REQ-033 WRITE 0x55 at 0x20, then WRITE 0xA5 at 0x20 with ce raised after 5 data bits -> READ at 0x20 returns 0x55.
REQ-034 With SPI_SRAM_MODE_REG_EN: WRMR 0x80, WRITE 3 bytes at 0x3F -> bytes at 0x3F, 0x20, 0x21; RDMR returns 0x80.
REQ-035 Reset pulsed during READ data phase -> so_oe=0 next clk, mode register 0x40, memory contents preserved.
